// File: rtl/button_ctrl_array_if.sv
// Pad-side and game-side signals of the button front-end, grouped for port use.
interface button_ctrl_array_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] rep_en;
  logic [N_BTN-1:0] pulse_out;
  logic [N_BTN-1:0] held;
  logic             chord;
  logic [N_BTN-1:0] select;

  modport master (output btn_in, rep_en, input pulse_out, held, chord, select);
  modport slave  (input btn_in, rep_en, output pulse_out, held, chord, select);
endinterface

// File: rtl/button_ctrl_array.sv
// Button front-end: synchronise, debounce, edge-detect and auto-repeat N_BTN raw
// inputs into registered action pulses, masked while a chord is held.
//
//   state  | meaning
//   IDLE   | button released, waiting for debounced press
//   DELAY  | pressed, counting towards the first auto-repeat
//   REPEAT | auto-repeating every REPEAT_RATE cycles
module button_ctrl_array #(
  parameter int N_BTN           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int MAX_ACTIVE      = 1
) (
  input logic               clk,
  input logic               reset,
  button_ctrl_array_if.slave bus
);
  localparam int DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int PCW  = $clog2(N_BTN + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] sync_d [SYNC_STAGES];
  logic [N_BTN-1:0] held_q, held_d;
  logic [DCW-1:0]   dcnt_q [N_BTN];
  logic [DCW-1:0]   dcnt_d [N_BTN];
  state_t           st_q   [N_BTN];
  state_t           st_d   [N_BTN];
  logic [RCW-1:0]   rcnt_q [N_BTN];
  logic [RCW-1:0]   rcnt_d [N_BTN];
  logic [N_BTN-1:0] raw_pulse;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] select_q, select_d;
  logic             chord_q, chord_d;
  logic [PCW-1:0]   n_held;
  logic [N_BTN-1:0] s;

  always_comb begin
    sync_d[0] = bus.btn_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    held_d = held_q;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i] = '0;
      if (s[i] != held_q[i]) begin
        if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) held_d[i] = s[i];
        else                                         dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  // Channel FSMs run on the registered held level, so press and release are
  // seen one cycle after the debouncer commits them.
  always_comb begin
    raw_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      case (st_q[i])
        IDLE: begin
          if (held_q[i]) begin
            raw_pulse[i] = 1'b1;
            rcnt_d[i]    = '0;
            st_d[i]      = DELAY;
          end
        end
        DELAY: begin
          if (!held_q[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (!bus.rep_en[i]) begin
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == RCW'(REPEAT_DELAY - 1)) begin
            raw_pulse[i] = 1'b1;
            rcnt_d[i]    = '0;
            st_d[i]      = REPEAT;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (!held_q[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (!bus.rep_en[i]) begin
            st_d[i]   = DELAY;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == RCW'(REPEAT_RATE - 1)) begin
            raw_pulse[i] = 1'b1;
            rcnt_d[i]    = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]   = IDLE;
          rcnt_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    n_held = '0;
    for (int i = 0; i < N_BTN; i++) n_held = n_held + PCW'(held_q[i]);
    chord_d  = (int'(n_held) > MAX_ACTIVE);
    pulse_d  = raw_pulse & {N_BTN{~chord_d}};
    select_d = (pulse_q != '0) ? (pulse_q & (-pulse_q)) : select_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
        rcnt_q[i] <= '0;
      end
      held_q   <= '0;
      pulse_q  <= '0;
      select_q <= '0;
      chord_q  <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
      held_q   <= held_d;
      pulse_q  <= pulse_d;
      select_q <= select_d;
      chord_q  <= chord_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.held      = held_q;
  assign bus.chord     = chord_q;
  assign bus.select    = select_q;
endmodule
